// File: rtl/lcd_pattern_gen_if.sv
// rtl/lcd_pattern_gen_if.sv - timing-generator pixel bus into the pattern generator and RGB565 out
interface lcd_pattern_gen_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       de;
  logic       hsync;
  logic       vsync;
  logic       frame;
  logic [4:0] r;
  logic [5:0] g;
  logic [4:0] b;
  logic       de_o;
  logic       hsync_o;
  logic       vsync_o;

  modport master (
    output x, y, de, hsync, vsync, frame,
    input  r, g, b, de_o, hsync_o, vsync_o
  );

  modport slave (
    input  x, y, de, hsync, vsync, frame,
    output r, g, b, de_o, hsync_o, vsync_o
  );
endinterface

// File: rtl/lcd_pattern_gen.sv
// rtl/lcd_pattern_gen.sv - two-stage RGB565 test pattern source with debounced mode button and bouncing box
module lcd_pattern_gen #(
  parameter int SCREEN_W        = 800,
  parameter int SCREEN_H        = 480,
  parameter int BOX_SIZE        = 64,
  parameter int BOX_STEP        = 2,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn,
  output logic [1:0]          mode,
  lcd_pattern_gen_if.slave    bus
);
  localparam int LX = SCREEN_W - BOX_SIZE;
  localparam int LY = SCREEN_H - BOX_SIZE;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_btn_s1, r_btn_s2, r_btn_db;
  logic [CW-1:0] r_db_cnt;
  logic [1:0]    r_mode_pending, r_mode;
  logic [9:0]    r_bx, r_by;
  logic          r_dx, r_dy;

  logic [4:0]    r_xg1;
  logic [5:0]    r_yg1;
  logic          r_de1, r_hs1, r_vs1, r_chk1, r_hit1;
  logic [2:0]    r_bar1;

  logic [4:0]    r_r, r_b;
  logic [5:0]    r_g;
  logic          r_de2, r_hs2, r_vs2;

  logic          w_db_done;
  logic [10:0]   w_bx_inc, w_by_inc;
  logic [2:0]    w_bar;
  logic          w_hit;
  logic [4:0]    w_r, w_b;
  logic [5:0]    w_g;

  assign w_db_done = (r_btn_s2 != r_btn_db) && (r_db_cnt == CW'(DEBOUNCE_CYCLES - 1));

  // The pending increment and the frame-time mode load share an edge, so mode sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_s1       <= 1'b0;
      r_btn_s2       <= 1'b0;
      r_btn_db       <= 1'b0;
      r_db_cnt       <= '0;
      r_mode_pending <= 2'd0;
      r_mode         <= 2'd0;
    end else begin
      r_btn_s1 <= btn;
      r_btn_s2 <= r_btn_s1;
      if (r_btn_s2 == r_btn_db) begin
        r_db_cnt <= '0;
      end else if (w_db_done) begin
        r_db_cnt <= '0;
        r_btn_db <= r_btn_s2;
      end else begin
        r_db_cnt <= r_db_cnt + CW'(1);
      end
      if (w_db_done && r_btn_s2) r_mode_pending <= r_mode_pending + 2'd1;
      if (bus.frame) r_mode <= r_mode_pending;
    end
  end

  assign w_bx_inc = {1'b0, r_bx} + 11'(BOX_STEP);
  assign w_by_inc = {1'b0, r_by} + 11'(BOX_STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bx <= 10'd0;
      r_by <= 10'd0;
      r_dx <= 1'b1;
      r_dy <= 1'b1;
    end else if (bus.frame) begin
      if (r_dx) begin
        if (w_bx_inc >= 11'(LX)) begin
          r_bx <= 10'(LX);
          r_dx <= 1'b0;
        end else begin
          r_bx <= w_bx_inc[9:0];
        end
      end else if (r_bx <= 10'(BOX_STEP)) begin
        r_bx <= 10'd0;
        r_dx <= 1'b1;
      end else begin
        r_bx <= r_bx - 10'(BOX_STEP);
      end
      if (r_dy) begin
        if (w_by_inc >= 11'(LY)) begin
          r_by <= 10'(LY);
          r_dy <= 1'b0;
        end else begin
          r_by <= w_by_inc[9:0];
        end
      end else if (r_by <= 10'(BOX_STEP)) begin
        r_by <= 10'd0;
        r_dy <= 1'b1;
      end else begin
        r_by <= r_by - 10'(BOX_STEP);
      end
    end
  end

  // Bar index is the count of 100-pixel thresholds passed, avoiding a divider.
  always_comb begin
    w_bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (bus.x >= 10'(100 * k)) w_bar = w_bar + 3'd1;
    end
  end

  assign w_hit = (bus.x >= r_bx) && ({1'b0, bus.x} < {1'b0, r_bx} + 11'(BOX_SIZE)) &&
                 (bus.y >= r_by) && ({1'b0, bus.y} < {1'b0, r_by} + 11'(BOX_SIZE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xg1  <= 5'd0;
      r_yg1  <= 6'd0;
      r_de1  <= 1'b0;
      r_hs1  <= 1'b1;
      r_vs1  <= 1'b1;
      r_bar1 <= 3'd0;
      r_chk1 <= 1'b0;
      r_hit1 <= 1'b0;
    end else begin
      r_xg1  <= bus.x[9:5];
      r_yg1  <= bus.y[8:3];
      r_de1  <= bus.de;
      r_hs1  <= bus.hsync;
      r_vs1  <= bus.vsync;
      r_bar1 <= w_bar;
      r_chk1 <= bus.x[5] ^ bus.y[5];
      r_hit1 <= w_hit;
    end
  end

  always_comb begin
    w_r = 5'd0;
    w_g = 6'd0;
    w_b = 5'd0;
    if (r_de1) begin
      case (r_mode)
        2'd0: begin
          w_r = (r_bar1 == 3'd0 || r_bar1 == 3'd1 || r_bar1 == 3'd4 || r_bar1 == 3'd5) ? 5'd31 : 5'd0;
          w_g = (r_bar1 <= 3'd3) ? 6'd63 : 6'd0;
          w_b = (r_bar1 == 3'd0 || r_bar1 == 3'd2 || r_bar1 == 3'd4 || r_bar1 == 3'd6) ? 5'd31 : 5'd0;
        end
        2'd1: begin
          w_r = {5{r_chk1}};
          w_g = {6{r_chk1}};
          w_b = {5{r_chk1}};
        end
        2'd2: begin
          w_r = r_xg1;
          w_g = r_yg1;
          w_b = 5'd31 - r_xg1;
        end
        default: begin
          w_r = r_hit1 ? 5'd31 : 5'd0;
          w_b = r_hit1 ? 5'd0 : 5'd31;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r   <= 5'd0;
      r_g   <= 6'd0;
      r_b   <= 5'd0;
      r_de2 <= 1'b0;
      r_hs2 <= 1'b1;
      r_vs2 <= 1'b1;
    end else begin
      r_r   <= w_r;
      r_g   <= w_g;
      r_b   <= w_b;
      r_de2 <= r_de1;
      r_hs2 <= r_hs1;
      r_vs2 <= r_vs1;
    end
  end

  assign bus.r       = r_r;
  assign bus.g       = r_g;
  assign bus.b       = r_b;
  assign bus.de_o    = r_de2;
  assign bus.hsync_o = r_hs2;
  assign bus.vsync_o = r_vs2;
  assign mode        = r_mode;
endmodule

// File: tb/tb_lcd_pattern_gen.sv
// tb/tb_lcd_pattern_gen.sv - randomized pixel stream against a frame-level reference model
module tb_lcd_pattern_gen;
  localparam int DEB = 16;
  localparam int W   = 800;
  localparam int H   = 480;
  localparam int BS  = 64;
  localparam int ST  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn;
  logic [1:0] mode;

  lcd_pattern_gen_if bus ();

  lcd_pattern_gen #(
    .SCREEN_W(W), .SCREEN_H(H), .BOX_SIZE(BS), .BOX_STEP(ST), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .mode(mode), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_mode, m_pend, m_bx, m_by, m_dx, m_dy, nframes;
  logic [18:0] expq[$];
  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] colour(int md, int x, int y);
    case (md)
      0: return bars[x / 100];
      1: return (((x / 32) + (y / 32)) % 2 == 1) ? 16'hFFFF : 16'h0000;
      2: return {5'(x / 32), 6'(y / 8), 5'(31 - x / 32)};
      default: return (x >= m_bx && x < m_bx + BS && y >= m_by && y < m_by + BS) ? 16'hF800 : 16'h001F;
    endcase
  endfunction

  task automatic axis(inout int p, inout int d, input int lim);
    if (d == 1) begin
      if (p + ST >= lim) begin p = lim; d = 0; end
      else p = p + ST;
    end else begin
      if (p <= ST) begin p = 0; d = 1; end
      else p = p - ST;
    end
  endtask

  task automatic cycle(input bit de, input int x, input int y, input bit hs, input bit vs, input bit fr);
    logic [18:0] e;
    bus.de = de; bus.x = 10'(x); bus.y = 10'(y);
    bus.hsync = hs; bus.vsync = vs; bus.frame = fr;
    expq.push_back({de ? colour(m_mode, x, y) : 16'h0, de, hs, vs});
    if (fr) begin
      m_mode = m_pend;
      axis(m_bx, m_dx, W - BS);
      axis(m_by, m_dy, H - BS);
      nframes++;
    end
    @(posedge clk);
    #1;
    e = expq.pop_front();
    check("pix", {bus.r, bus.g, bus.b, bus.de_o, bus.hsync_o, bus.vsync_o}, e);
    check("mode", mode, m_mode);
  endtask

  function automatic int pick(int lim, int grid, int base);
    int v;
    case ($urandom_range(0, 3))
      0: v = $urandom_range(0, lim - 1);
      1: v = grid * $urandom_range(1, 7) - $urandom_range(0, 1);
      2: v = base - 1 + $urandom_range(0, 1);
      default: v = base + BS - 1 + $urandom_range(0, 1);
    endcase
    if (v < 0) v = 0;
    if (v >= lim) v = lim - 1;
    return v;
  endfunction

  task automatic rand_cycle();
    bit de;
    de = ($urandom_range(0, 3) != 0);
    if (de) cycle(1'b1, pick(W, 100, m_bx), pick(H, 32, m_by),
                  ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0), 1'b0);
    else    cycle(1'b0, $urandom_range(0, 1023), $urandom_range(0, 1023),
                  ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0), 1'b0);
  endtask

  task automatic frame_cycle();
    cycle(1'b0, $urandom_range(0, 1023), $urandom_range(0, 1023), 1'b1, 1'b1, 1'b1);
    check("bx", dut.r_bx, m_bx);
    check("by", dut.r_by, m_by);
  endtask

  task automatic press(input int len);
    btn = 1'b1;
    repeat (len) rand_cycle();
    btn = 1'b0;
    if (len >= DEB) m_pend = (m_pend + 1) % 4;
    repeat (DEB + 4) rand_cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.de = 1'b0; bus.hsync = 1'b1; bus.vsync = 1'b1; bus.frame = 1'b0; btn = 1'b0;
    #1;
    check("rst_rgb", {bus.r, bus.g, bus.b}, 16'h0);
    check("rst_syncs", {bus.de_o, bus.hsync_o, bus.vsync_o}, 3'b011);
    check("rst_mode", mode, 2'd0);
    check("rst_box", {dut.r_bx, dut.r_by, dut.r_dx, dut.r_dy}, {10'd0, 10'd0, 1'b1, 1'b1});
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_mode = 0; m_pend = 0; m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1; nframes = 0;
    expq.delete();
    expq.push_back({16'h0, 1'b0, 1'b1, 1'b1});
  endtask

  initial begin
    #5000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    bus.x = 10'd0; bus.y = 10'd0; bus.de = 1'b0; bus.hsync = 1'b1; bus.vsync = 1'b1;
    bus.frame = 1'b0; btn = 1'b0;
    #2;
    do_reset();

    cycle(1'b1, 0, 0, 1'b1, 1'b1, 1'b0);
    check("lat_de_early", bus.de_o, 1'b0);
    cycle(1'b1, 99, 0, 1'b1, 1'b1, 1'b0);
    check("lat_white", {bus.r, bus.g, bus.b, bus.de_o}, {16'hFFFF, 1'b1});
    cycle(1'b1, 100, 0, 1'b0, 1'b1, 1'b0);
    check("bar99", {bus.r, bus.g, bus.b}, 16'hFFFF);
    cycle(1'b1, 699, 0, 1'b1, 1'b1, 1'b0);
    check("bar100", {bus.r, bus.g, bus.b, bus.hsync_o}, {16'hFFE0, 1'b0});
    cycle(1'b1, 700, 0, 1'b1, 1'b1, 1'b0);
    check("bar699", {bus.r, bus.g, bus.b, bus.hsync_o}, {16'h001F, 1'b1});
    cycle(1'b0, 150, 0, 1'b1, 1'b1, 1'b0);
    check("bar700", {bus.r, bus.g, bus.b}, 16'h0000);
    cycle(1'b0, 150, 0, 1'b1, 1'b1, 1'b0);
    check("blank150", {bus.r, bus.g, bus.b, bus.de_o}, 17'h0);
    repeat (150) rand_cycle();

    press(DEB - 1);
    press($urandom_range(1, DEB - 2));
    frame_cycle();
    check("short_press_mode", mode, 2'd0);
    check("box_1frame", {dut.r_bx, dut.r_by}, {10'd2, 10'd2});

    press(DEB + 2);
    check("mode_hold", mode, 2'd0);
    frame_cycle();
    check("mode_one", mode, 2'd1);
    repeat (150) rand_cycle();

    press(DEB);
    frame_cycle();
    repeat (150) rand_cycle();

    press($urandom_range(DEB + 1, 2 * DEB));
    frame_cycle();
    repeat (300) rand_cycle();

    while (nframes < 368) begin
      frame_cycle();
      rand_cycle();
    end
    check("bx_368", {dut.r_bx, dut.r_dx}, {10'd736, 1'b0});
    repeat (60) rand_cycle();
    while (nframes < 416) begin
      frame_cycle();
      rand_cycle();
    end
    check("by_416", {dut.r_by, dut.r_dy}, {10'd0, 1'b1});
    repeat (60) rand_cycle();

    press(DEB + 2);
    frame_cycle();
    check("mode_wrap", mode, 2'd0);
    repeat (60) rand_cycle();

    press(DEB + 2);
    frame_cycle();
    press(DEB + 2);
    frame_cycle();
    repeat (3) cycle(1'b1, 400, 200, 1'b1, 1'b1, 1'b0);
    check("pre_rst_mode2", mode, 2'd2);
    #3;
    do_reset();
    repeat (60) rand_cycle();
    check("post_rst", {dut.r_bx, 6'd0, mode}, {10'd0, 6'd0, 2'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_pattern_gen.md
# lcd_pattern_gen

Pixel-source stage placed directly downstream of the LCD timing generator. It consumes the pixel coordinates (`x`, `y`), the `de`, `hsync` and `vsync` strobes, and the per-frame `frame` pulse. It produces RGB565 pixel data with delay-matched sync and enable signals for the 800×480 panel. It offers four selectable test patterns, one of them an animated bouncing box; a debounced push-button cycles through the patterns.

## Interface
- `SCREEN_W`, default 800: active width in pixels.
- `SCREEN_H`, default 480: active height in lines.
- `BOX_SIZE`, default 64: bouncing-box edge length in pixels.
- `BOX_STEP`, default 2: box displacement per frame on each axis, in pixels.
- `DEBOUNCE_CYCLES`, default 240000: number of stable clocks before a button level is accepted.
- `clk`  in  1  pixel clock, shared with the timing generator.
- `rst`  in  1  asynchronous, active-high reset.
- `x`  in  10  pixel column from the timing generator; valid only while `de`=1.
- `y`  in  10  pixel line; valid only while `de`=1.
- `de`  in  1  data enable.
- `hsync`  in  1  horizontal sync, active-low.
- `vsync`  in  1  vertical sync, active-low.
- `frame`  in  1  single-cycle pulse on the last clock of each frame.
- `btn`  in  1  raw, asynchronous, active-high mode button.
- `r`  out  5  red.
- `g`  out  6  green.
- `b`  out  5  blue.
- `de_o`  out  1  `de` delayed by 2 clocks.
- `hsync_o`  out  1  `hsync` delayed by 2 clocks.
- `vsync_o`  out  1  `vsync` delayed by 2 clocks.
- `mode`  out  2  currently displayed pattern.

## Operation
- **Button path**
  - 2-FF synchronizer feeds a debouncer. A level change resets the debounce counter.
  - The debounced state updates after the synchronized level has been stable for `DEBOUNCE_CYCLES` consecutive clocks.
  - A rising edge of the debounced state increments `mode_pending` (2 bits, 3 wraps to 0).
- **Mode latch:** `mode` loads `mode_pending` only on a cycle with `frame`=1. There are no mid-frame pattern changes.
- **Patterns:** output colours are given as (r,g,b).
  - Mode 0, colour bars: bar index = the k with 100·k ≤ x < 100·(k+1). Implement with comparators, no divider. Bars in order:
    - white (31,63,31)
    - yellow (31,63,0)
    - cyan (0,63,31)
    - green (0,63,0)
    - magenta (31,0,31)
    - red (31,0,0)
    - blue (0,0,31)
    - black (0,0,0)
  - Mode 1, checkerboard: x[5]^y[5]=1 gives white, otherwise black.
  - Mode 2, gradient: r = x[9:5], g = y[8:3], b = 31 − x[9:5]. All values are in range for x<800 and y<480.
  - Mode 3, box: pixel inside the box (bx ≤ x < bx+BOX_SIZE and by ≤ y < by+BOX_SIZE) is red, otherwise blue.
- **Box motion:** registers `bx`, `by` (10 b) and direction bits `dx`, `dy` (1 = increasing). They update only on `frame`=1, in every mode. Per axis, with limit L = SCREEN_W − BOX_SIZE for x and SCREEN_H − BOX_SIZE for y:
  - If increasing and bx + BOX_STEP ≥ L: bx ← L, dx ← 0.
  - Else if increasing: bx ← bx + BOX_STEP.
  - If decreasing and bx ≤ BOX_STEP: bx ← 0, dx ← 1.
  - Else if decreasing: bx ← bx − BOX_STEP.
  - The y axis follows the same rules.
- **Blanking:** whenever the delayed `de` is 0, r/g/b are forced to 0 regardless of mode. Garbage x/y outside the active area must never reach the outputs.
- **Reset (asynchronous):** all of the following are cleared or set immediately:
  - r/g/b = 0, `de_o` = 0, `hsync_o` = 1, `vsync_o` = 1.
  - `mode` = `mode_pending` = 0.
  - bx = by = 0, dx = dy = 1.
  - Debouncer state = 0, debounce counter = 0.

## Timing
- Stage 1 registers x, y, de, hsync and vsync, and computes the region flags: bar index, checker bit and box-hit.
- Stage 2 computes and registers the colour, `de_o`, `hsync_o` and `vsync_o`.
- Latency is exactly 2 clocks from input to output for colour and syncs alike. Relative sync/de alignment is preserved cycle-for-cycle.
- `mode`, `bx` and `by` change on the clock edge that samples `frame`=1. The new values apply to every pixel of the following frame.
- Button press coinciding with `frame`: the `mode_pending` increment and the `mode` load occur on the same edge. `mode` takes the pre-increment value; the increment shows on the next frame.
- Reset asserted mid-frame: outputs take reset values immediately. After release, normal 2-clock latency resumes with the next sampled inputs. No partial box update survives.

## Test plan
- **Reset and latency:** reset, release, drive de=1, x=0, y=0 in mode 0 → 2 clocks later `de_o`=1 and rgb=(31,63,31). An hsync low pulse appears on `hsync_o` exactly 2 clocks later.
- **Colour bars:** in mode 0, x=99 → white; x=100 → yellow; x=699 → blue; x=700 → black. With de=0 and x=150 → rgb=0.
- **Button and mode latch:**
  - Button held for `DEBOUNCE_CYCLES`−1 clocks and then released → mode stays 0.
  - Button held for `DEBOUNCE_CYCLES`+2 clocks → `mode` stays 0 until the next `frame` pulse, then becomes 1.
  - Four valid presses across frames → mode wraps to 0.
- **Box bounce:**
  - With BOX_STEP=2, after 1 frame pulse → bx=by=2.
  - After 368 frame pulses → bx=736 with dx=0.
  - by reaches 416, then reverses and returns to 0 with dy=1.
- **Box rendering:** mode 3 with bx=by=0 → pixel (63,63) is red and (64,0) is blue.
- **Reset mid-operation:** assert rst with mode=2 and bx=100 mid-line → all outputs take reset values immediately; mode=0 and bx=0 after release.
